list_fetch: RTL and testbench

//  Upstream feeder for the list cache: walks a list in memory from BASE_ADDR for LENGTH elements.

---
 rtl/list_fetch.sv | 187 ++++++++++++++++++
 tb/tb_list_fetch.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_fetch.sv
// list_fetch
//   Upstream feeder for the list cache. Walks LENGTH elements starting at
//   BASE_ADDR, issuing in-order single-word reads and forwarding each returned
//   word to the cache as LIST_IN with a one-cycle LIST_NEXT_READY strobe.
//   A credit counter (CREDITS deep) bounds words in flight plus words
//   buffered downstream; ARG_RECEIVED returns one credit.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   START             begin a fetch (sampled only in IDLE)
//   BASE_ADDR, LENGTH first byte address / element count, captured on START
//   RD_ADDR           read request address (stable until accepted)
//   RD_REQ_VALID      read request valid
//   RD_REQ_READY      read request accepted when VALID & READY
//   RD_DATA           read response data, returned in request order
//   RD_DATA_VALID     read response strobe
//   LIST_IN           element to cache (holds between strobes)
//   LIST_NEXT_READY   one-cycle strobe: LIST_IN carries a new element
//   ARG_RECEIVED      cache consumed one element (returns a credit)
//   BUSY              high outside IDLE
//   DONE              one-cycle pulse once the last element is delivered
//   ERR               (only with LIST_FETCH_ERR_EN) sticky protocol error:
//                     response with nothing outstanding, or a credit return
//                     while credits are already full
//
// Configuration macro: LIST_FETCH_ERR_EN adds the ERR output.
module list_fetch #(
   parameter int TYPE_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int CREDITS    = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [LEN_WIDTH-1:0]  LENGTH,
   output logic [ADDR_WIDTH-1:0] RD_ADDR,
   output logic                  RD_REQ_VALID,
   input  logic                  RD_REQ_READY,
   input  logic [TYPE_WIDTH-1:0] RD_DATA,
   input  logic                  RD_DATA_VALID,
   output logic [TYPE_WIDTH-1:0] LIST_IN,
   output logic                  LIST_NEXT_READY,
   input  logic                  ARG_RECEIVED,
   output logic                  BUSY,
   output logic                  DONE
`ifdef LIST_FETCH_ERR_EN
   ,
   output logic                  ERR
`endif
);

   localparam int CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0]         CRED_MAX = CW'(CREDITS);
   localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(TYPE_WIDTH / 8);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t               state;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] issued;
   logic [LEN_WIDTH-1:0] delivered;
   logic [CW-1:0]        credits;
   logic [CW-1:0]        outstanding;

   logic                 accept;
   logic                 resp;
   logic                 last_delivery;
   logic [CW-1:0]        credits_nxt;
   logic [CW-1:0]        outstanding_nxt;
   logic [LEN_WIDTH-1:0] issued_nxt;

   // Handshake decode and next-state counters
   always_comb begin
      accept          = RD_REQ_VALID & RD_REQ_READY;
      // A response is only meaningful while something is outstanding;
      // stray words (e.g. from a fetch aborted by reset) are dropped here.
      resp            = RD_DATA_VALID & (outstanding != '0);
      last_delivery   = resp & ((delivered + LEN_WIDTH'(1)) == len_q);

      credits_nxt     = credits;
      if (accept && !ARG_RECEIVED)
         credits_nxt = credits - CW'(1);
      else if (!accept && ARG_RECEIVED && (credits != CRED_MAX))
         credits_nxt = credits + CW'(1);

      outstanding_nxt = outstanding;
      if (accept && !resp)
         outstanding_nxt = outstanding + CW'(1);
      else if (!accept && resp)
         outstanding_nxt = outstanding - CW'(1);

      issued_nxt      = issued;
      if (accept)
         issued_nxt = issued + LEN_WIDTH'(1);
   end

   // Control FSM with registered outputs. RD_REQ_VALID is computed from the
   // next-cycle credit/issue counts so it always equals
   // (ISSUE && credits>0 && issued<len) for the cycle it is visible in.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state           <= S_IDLE;
         len_q           <= '0;
         issued          <= '0;
         delivered       <= '0;
         credits         <= CRED_MAX;
         outstanding     <= '0;
         RD_ADDR         <= '0;
         RD_REQ_VALID    <= 1'b0;
         LIST_IN         <= '0;
         LIST_NEXT_READY <= 1'b0;
         BUSY            <= 1'b0;
         DONE            <= 1'b0;
      end else begin
         credits         <= credits_nxt;
         outstanding     <= outstanding_nxt;
         issued          <= issued_nxt;
         LIST_NEXT_READY <= resp;
         DONE            <= 1'b0;

         if (resp) begin
            LIST_IN   <= RD_DATA;
            delivered <= delivered + LEN_WIDTH'(1);
         end

         // Address advances only on acceptance, so it is stable while stalled.
         if (accept)
            RD_ADDR <= RD_ADDR + STRIDE;

         case (state)
            S_IDLE: begin
               if (START) begin
                  len_q     <= LENGTH;
                  RD_ADDR   <= BASE_ADDR;
                  issued    <= '0;
                  delivered <= '0;
                  BUSY      <= 1'b1;
                  if (LENGTH == '0) begin
                     state <= S_DONE;
                     DONE  <= 1'b1;
                  end else begin
                     state        <= S_ISSUE;
                     RD_REQ_VALID <= (credits_nxt != '0);
                  end
               end
            end
            S_ISSUE: begin
               if (issued_nxt == len_q) begin
                  state        <= S_DRAIN;
                  RD_REQ_VALID <= 1'b0;
               end else begin
                  RD_REQ_VALID <= (credits_nxt != '0);
               end
            end
            S_DRAIN: begin
               if (last_delivery) begin
                  state <= S_DONE;
                  DONE  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state        <= S_IDLE;
               RD_REQ_VALID <= 1'b0;
               BUSY         <= 1'b0;
            end
         endcase
      end
   end

`ifdef LIST_FETCH_ERR_EN
   // Sticky protocol error flag, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (RESET)
         ERR <= 1'b0;
      else if ((RD_DATA_VALID && (outstanding == '0)) ||
               (ARG_RECEIVED && (credits == CRED_MAX)))
         ERR <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_list_fetch.sv
`timescale 1ns/1ps
module tb_list_fetch;
   localparam int TW = 32;
   localparam int AW = 32;
   localparam int LW = 16;
   localparam int CR = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          START;
   logic [AW-1:0] BASE_ADDR;
   logic [LW-1:0] LENGTH;
   logic [AW-1:0] RD_ADDR;
   logic          RD_REQ_VALID;
   logic          RD_REQ_READY;
   logic [TW-1:0] RD_DATA;
   logic          RD_DATA_VALID;
   logic [TW-1:0] LIST_IN;
   logic          LIST_NEXT_READY;
   logic          ARG_RECEIVED;
   logic          BUSY;
   logic          DONE;
`ifdef LIST_FETCH_ERR_EN
   logic          ERR;
`endif

   list_fetch #(.TYPE_WIDTH(TW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CREDITS(CR)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH),
      .RD_ADDR(RD_ADDR), .RD_REQ_VALID(RD_REQ_VALID), .RD_REQ_READY(RD_REQ_READY),
      .RD_DATA(RD_DATA), .RD_DATA_VALID(RD_DATA_VALID), .LIST_IN(LIST_IN),
      .LIST_NEXT_READY(LIST_NEXT_READY), .ARG_RECEIVED(ARG_RECEIVED), .BUSY(BUSY),
      .DONE(DONE)
`ifdef LIST_FETCH_ERR_EN
      , .ERR(ERR)
`endif
   );

   always #5 CLK = ~CLK;

   int vectors     = 0;
   int miscompares = 0;

   // Observation logs and memory/cache model state (owned by the model process)
   logic [AW-1:0] acc_q[$];
   logic [TW-1:0] strobe_q[$];
   logic [AW-1:0] pend_addr[$];
   int            pend_due[$];
   int            cyc         = 0;
   int            done_total  = 0;
   int            infl        = 0;
   int            owed        = 0;
   int            credit_viol = 0;
   int            ack_done    = 0;
   // Knobs written by the main process
   int            ack_req     = 0;
   bit            ack_auto    = 1'b1;
   int            lat_min     = 2;
   int            lat_rnd     = 0;

   // Memory contents: a fixed scramble of the address.
   function automatic logic [TW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   // Memory responder + cache model. Observes at negedge, drives at posedge+1.
   // infl = words accepted but not yet acknowledged by the cache; the spec
   // bounds this by CR, so an accept with infl==CR is a credit violation.
   initial begin
      RD_DATA_VALID = 1'b0;
      RD_DATA       = '0;
      ARG_RECEIVED  = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            infl = 0;
            owed = 0;
         end else begin
            if (RD_REQ_VALID && RD_REQ_READY) begin
               if (infl >= CR) credit_viol++;
               acc_q.push_back(RD_ADDR);
               pend_addr.push_back(RD_ADDR);
               pend_due.push_back(cyc + lat_min + int'($urandom_range(0, lat_rnd)));
               infl++;
            end
            if (ARG_RECEIVED) infl--;
            if (LIST_NEXT_READY) begin
               strobe_q.push_back(LIST_IN);
               owed++;
            end
            if (DONE) done_total++;
         end
         @(posedge CLK);
         #1;
         cyc++;
         if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            RD_DATA_VALID = 1'b1;
            RD_DATA       = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            RD_DATA_VALID = 1'b0;
            RD_DATA       = $urandom;
         end
         if (owed > 0 && ack_req != ack_done) begin
            ARG_RECEIVED = 1'b1;
            ack_done++;
            owed--;
         end else if (owed > 0 && ack_auto && $urandom_range(0, 2) != 0) begin
            ARG_RECEIVED = 1'b1;
            owed--;
         end else begin
            ARG_RECEIVED = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_fetch(input logic [AW-1:0] b, input logic [LW-1:0] l);
      BASE_ADDR = b;
      LENGTH    = l;
      START     = 1'b1;
      tick();
      START     = 1'b0;
      BASE_ADDR = $urandom;       // captured values must not follow the inputs
      LENGTH    = LW'($urandom);
   endtask

   task automatic wait_done(input int d0, input bit rnd_ready, input bit poke, output bit ok);
      int n;
      bit poked;
      n = 0;
      poked = 1'b0;
      while (done_total == d0 && n < 3000) begin
         if (rnd_ready) RD_REQ_READY = ($urandom_range(0, 3) != 0);
         if (poke && !poked && BUSY && !DONE && n > 1) begin
            START  = 1'b1;        // must be ignored: fetch in progress
            LENGTH = LW'($urandom_range(1, 50));
            poked  = 1'b1;
         end else begin
            START = 1'b0;
         end
         tick();
         n++;
      end
      START = 1'b0;
      ok = (done_total != d0);
   endtask

   task automatic drain(output bit ok);
      int n;
      n = 0;
      while ((pend_due.size() != 0 || owed != 0) && n < 300) begin
         tick();
         n++;
      end
      repeat (3) tick();
      ok = (n < 300);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; RD_REQ_READY = 1'b1; BASE_ADDR = 32'hDEAD_BEEF; LENGTH = 16'd5;
      repeat (3) tick();
      vectors++; if (RD_REQ_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", RD_REQ_VALID); end
      vectors++; if (RD_ADDR !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", RD_ADDR); end
      vectors++; if (LIST_IN !== 32'h0) begin miscompares++; $display("FAIL reset_list_in: got %h want 0", LIST_IN); end
      vectors++; if (LIST_NEXT_READY !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b want 0", LIST_NEXT_READY); end
      vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      vectors++; if (DONE !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", DONE); end
`ifdef LIST_FETCH_ERR_EN
      vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", ERR); end
`endif
      RESET = 1'b0;
      repeat (2) tick();
      vectors++; if (BUSY !== 1'b0 || RD_REQ_VALID !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", BUSY, RD_REQ_VALID); end
   endtask

   task automatic test_basic();
      int a0, s0, d0;
      bit ok;
      logic [AW-1:0] ea;
      lat_min = 2; lat_rnd = 0; ack_auto = 1'b1; RD_REQ_READY = 1'b1;
      a0 = acc_q.size(); s0 = strobe_q.size(); d0 = done_total;
      start_fetch(32'h0000_1000, 16'd3);
      wait_done(d0, 1'b0, 1'b0, ok);
      repeat (3) tick();
      vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout: done not seen, required within budget"); end
      vectors++; if (acc_q.size() - a0 != 3) begin miscompares++; $display("FAIL basic_req_count: got %0d want 3", acc_q.size() - a0); end
      vectors++; if (strobe_q.size() - s0 != 3) begin miscompares++; $display("FAIL basic_strobe_count: got %0d want 3", strobe_q.size() - s0); end
      for (int i = 0; i < 3; i++) begin
         ea = 32'h0000_1000 + AW'(4 * i);
         if (a0 + i < acc_q.size()) begin
            vectors++; if (acc_q[a0 + i] !== ea) begin miscompares++; $display("FAIL basic_addr[%0d]: got %h want %h", i, acc_q[a0 + i], ea); end
         end
         if (s0 + i < strobe_q.size()) begin
            vectors++; if (strobe_q[s0 + i] !== mem_word(ea)) begin miscompares++; $display("FAIL basic_data[%0d]: got %h want %h", i, strobe_q[s0 + i], mem_word(ea)); end
         end
      end
      vectors++; if (done_total - d0 != 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_total - d0); end
      vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", BUSY); end
      vectors++; if (LIST_IN !== mem_word(32'h0000_1008)) begin miscompares++; $display("FAIL basic_list_in_hold: got %h want %h", LIST_IN, mem_word(32'h0000_1008)); end
   endtask

   task automatic test_credit_stall();
      int a0, s0, d0, n;
      bit ok;
      logic [AW-1:0] base, ea;
      drain(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL stall_predrain: queues not empty, required empty"); end
      lat_min = 2; lat_rnd = 0; ack_auto = 1'b0; RD_REQ_READY = 1'b1;
      base = $urandom;
      a0 = acc_q.size(); s0 = strobe_q.size(); d0 = done_total;
      start_fetch(base, 16'd6);
      repeat (20) tick();
      vectors++; if (acc_q.size() - a0 != CR) begin miscompares++; $display("FAIL stall_req_count: got %0d want %0d", acc_q.size() - a0, CR); end
      vectors++; if (strobe_q.size() - s0 != CR) begin miscompares++; $display("FAIL stall_strobe_count: got %0d want %0d", strobe_q.size() - s0, CR); end
      vectors++; if (RD_REQ_VALID !== 1'b0) begin miscompares++; $display("FAIL stall_valid_low: got %b want 0", RD_REQ_VALID); end
      ack_req++;
      n = 0;
      do begin @(negedge CLK); n++; end while (ARG_RECEIVED !== 1'b1 && n < 10);
      vectors++; if (ARG_RECEIVED !== 1'b1) begin miscompares++; $display("FAIL stall_ack_seen: got %b want 1", ARG_RECEIVED); end
      @(negedge CLK);
      vectors++; if (RD_REQ_VALID !== 1'b1) begin miscompares++; $display("FAIL stall_fifth_valid: got %b want 1", RD_REQ_VALID); end
      vectors++; if (RD_ADDR !== base + 32'd16) begin miscompares++; $display("FAIL stall_fifth_addr: got %h want %h", RD_ADDR, base + 32'd16); end
      @(posedge CLK); #1;
      ack_auto = 1'b1;
      wait_done(d0, 1'b0, 1'b0, ok);
      repeat (3) tick();
      vectors++; if (!ok) begin miscompares++; $display("FAIL stall_timeout: done not seen, required within budget"); end
      vectors++; if (acc_q.size() - a0 != 6) begin miscompares++; $display("FAIL stall_total_req: got %0d want 6", acc_q.size() - a0); end
      vectors++; if (strobe_q.size() - s0 != 6) begin miscompares++; $display("FAIL stall_total_strobe: got %0d want 6", strobe_q.size() - s0); end
      for (int i = 0; i < 6; i++) begin
         ea = base + AW'(4 * i);
         if (a0 + i < acc_q.size()) begin
            vectors++; if (acc_q[a0 + i] !== ea) begin miscompares++; $display("FAIL stall_addr[%0d]: got %h want %h", i, acc_q[a0 + i], ea); end
         end
         if (s0 + i < strobe_q.size()) begin
            vectors++; if (strobe_q[s0 + i] !== mem_word(ea)) begin miscompares++; $display("FAIL stall_data[%0d]: got %h want %h", i, strobe_q[s0 + i], mem_word(ea)); end
         end
      end
   endtask

   task automatic test_zero_len();
      int a0, d0;
      bit ok;
      drain(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL zero_predrain: queues not empty, required empty"); end
      a0 = acc_q.size(); d0 = done_total;
      start_fetch($urandom, 16'd0);
      vectors++; if (DONE !== 1'b1 || BUSY !== 1'b1) begin miscompares++; $display("FAIL zero_done_pulse: done=%b busy=%b want 1 1", DONE, BUSY); end
      tick();
      vectors++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin miscompares++; $display("FAIL zero_done_end: done=%b busy=%b want 0 0", DONE, BUSY); end
      repeat (2) tick();
      vectors++; if (acc_q.size() != a0 || RD_REQ_VALID !== 1'b0) begin miscompares++; $display("FAIL zero_no_request: reqs=%0d valid=%b want 0 0", acc_q.size() - a0, RD_REQ_VALID); end
      vectors++; if (done_total - d0 != 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_total - d0); end
   endtask

   task automatic test_ready_stall();
      int a0, d0, n;
      bit ok;
      logic [AW-1:0] base, ea;
      drain(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rdy_predrain: queues not empty, required empty"); end
      base = $urandom;
      RD_REQ_READY = 1'b0;
      a0 = acc_q.size(); d0 = done_total;
      start_fetch(base, 16'd3);
      n = 0;
      while (RD_REQ_VALID !== 1'b1 && n < 10) begin tick(); n++; end
      vectors++; if (RD_REQ_VALID !== 1'b1) begin miscompares++; $display("FAIL rdy_valid_rise: got %b want 1", RD_REQ_VALID); end
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++; if (RD_REQ_VALID !== 1'b1 || RD_ADDR !== base) begin miscompares++; $display("FAIL rdy_hold[%0d]: valid=%b addr=%h want 1 %h", i, RD_REQ_VALID, RD_ADDR, base); end
      end
      vectors++; if (acc_q.size() != a0) begin miscompares++; $display("FAIL rdy_no_accept: got %0d want 0", acc_q.size() - a0); end
      RD_REQ_READY = 1'b1;
      wait_done(d0, 1'b0, 1'b0, ok);
      repeat (3) tick();
      vectors++; if (!ok) begin miscompares++; $display("FAIL rdy_timeout: done not seen, required within budget"); end
      vectors++; if (acc_q.size() - a0 != 3) begin miscompares++; $display("FAIL rdy_req_count: got %0d want 3", acc_q.size() - a0); end
      for (int i = 0; i < 3; i++) begin
         ea = base + AW'(4 * i);
         if (a0 + i < acc_q.size()) begin
            vectors++; if (acc_q[a0 + i] !== ea) begin miscompares++; $display("FAIL rdy_addr[%0d]: got %h want %h", i, acc_q[a0 + i], ea); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int a0, s0, d0, n;
      bit ok;
      drain(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_predrain: queues not empty, required empty"); end
      lat_min = 8; lat_rnd = 0; RD_REQ_READY = 1'b1;
      a0 = acc_q.size(); s0 = strobe_q.size(); d0 = done_total;
      start_fetch($urandom, 16'd2);
      n = 0;
      while (acc_q.size() - a0 < 2 && n < 10) begin tick(); n++; end
      vectors++; if (acc_q.size() - a0 != 2 || strobe_q.size() != s0) begin miscompares++; $display("FAIL rstmid_two_outstanding: reqs=%0d strobes=%0d want 2 0", acc_q.size() - a0, strobe_q.size() - s0); end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      vectors++; if (RD_REQ_VALID !== 1'b0 || RD_ADDR !== 32'h0 || LIST_IN !== 32'h0) begin miscompares++; $display("FAIL rstmid_outputs: valid=%b addr=%h list_in=%h want 0 0 0", RD_REQ_VALID, RD_ADDR, LIST_IN); end
      vectors++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl: busy=%b done=%b want 0 0", BUSY, DONE); end
      n = 0;
      while (pend_due.size() != 0 && n < 30) begin tick(); n++; end
      repeat (2) tick();
      vectors++; if (pend_due.size() != 0) begin miscompares++; $display("FAIL rstmid_late_words: %0d pending, want 0", pend_due.size()); end
      vectors++; if (strobe_q.size() != s0) begin miscompares++; $display("FAIL rstmid_no_strobe: got %0d strobes want 0", strobe_q.size() - s0); end
      vectors++; if (done_total != d0 || BUSY !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: dones=%0d busy=%b want 0 0", done_total - d0, BUSY); end
`ifdef LIST_FETCH_ERR_EN
      vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL rstmid_err: got %b want 1", ERR); end
`endif
      lat_min = 2;
   endtask

   task automatic test_wrap();
      int a0, s0, d0;
      bit ok;
      drain(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_predrain: queues not empty, required empty"); end
      a0 = acc_q.size(); s0 = strobe_q.size(); d0 = done_total;
      start_fetch(32'hFFFF_FFFC, 16'd2);
      wait_done(d0, 1'b0, 1'b0, ok);
      repeat (3) tick();
      vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: done not seen, required within budget"); end
      vectors++; if (acc_q.size() - a0 != 2) begin miscompares++; $display("FAIL wrap_req_count: got %0d want 2", acc_q.size() - a0); end
      if (acc_q.size() - a0 >= 2) begin
         vectors++; if (acc_q[a0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0: got %h want fffffffc", acc_q[a0]); end
         vectors++; if (acc_q[a0 + 1] !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_addr1: got %h want 00000000", acc_q[a0 + 1]); end
      end
      if (strobe_q.size() - s0 >= 2) begin
         vectors++; if (strobe_q[s0 + 1] !== mem_word(32'h0)) begin miscompares++; $display("FAIL wrap_data1: got %h want %h", strobe_q[s0 + 1], mem_word(32'h0)); end
      end
   endtask

   task automatic test_back_to_back();
      int a0, s0, d0, len;
      bit ok;
      logic [AW-1:0] base, ea;
      lat_min = 1; lat_rnd = 3; ack_auto = 1'b1;
      for (int k = 0; k < 8; k++) begin
         base = $urandom;
         len  = int'($urandom_range(0, 10));
         a0 = acc_q.size(); s0 = strobe_q.size(); d0 = done_total;
         start_fetch(base, LW'(len));
         wait_done(d0, 1'b1, 1'b1, ok);
         RD_REQ_READY = 1'b1;
         repeat (2) tick();
         vectors++; if (!ok) begin miscompares++; $display("FAIL b2b[%0d]_timeout: done not seen, required within budget", k); end
         vectors++; if (acc_q.size() - a0 != len) begin miscompares++; $display("FAIL b2b[%0d]_req_count: got %0d want %0d", k, acc_q.size() - a0, len); end
         vectors++; if (strobe_q.size() - s0 != len) begin miscompares++; $display("FAIL b2b[%0d]_strobe_count: got %0d want %0d", k, strobe_q.size() - s0, len); end
         vectors++; if (done_total - d0 != 1) begin miscompares++; $display("FAIL b2b[%0d]_done_count: got %0d want 1", k, done_total - d0); end
         for (int i = 0; i < len; i++) begin
            ea = base + AW'(4 * i);
            if (a0 + i < acc_q.size()) begin
               vectors++; if (acc_q[a0 + i] !== ea) begin miscompares++; $display("FAIL b2b[%0d]_addr[%0d]: got %h want %h", k, i, acc_q[a0 + i], ea); end
            end
            if (s0 + i < strobe_q.size()) begin
               vectors++; if (strobe_q[s0 + i] !== mem_word(ea)) begin miscompares++; $display("FAIL b2b[%0d]_data[%0d]: got %h want %h", k, i, strobe_q[s0 + i], mem_word(ea)); end
            end
         end
      end
      drain(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_drain: queues not empty, required empty"); end
      vectors++; if (credit_viol != 0) begin miscompares++; $display("FAIL credit_bound: %0d accepts beyond %0d in flight, want 0", credit_viol, CR); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_credit_stall();
      test_zero_len();
      test_ready_stall();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
